stack_ctrl32x8: RTL and testbench

Push/pop controller for the 32x8 stack: sits directly upstream of the 32-word x 8-bit RAM. It owns the stack pointer, full/empty status and the request handshake. Each accepted request becomes one single-cycle RAM access, driving the RAM's address, data-in, read/write select and chip select. Popped data from the RAM output is captured into a registered output port.

---
 rtl/stack_pkg.sv | 14 +
 rtl/stack_ctrl32x8.sv | 129 ++++++++++++
 tb/tb_stack_ctrl32x8.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared defaults and FSM encoding for the 32x8 stack controller and its companions.
package stack_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } state_e;

endpackage

// File: rtl/stack_ctrl32x8.sv
// Push/pop controller for a 32x8 stack RAM: owns the stack pointer, status flags and
// the request handshake, turning each accepted request into one single-cycle RAM access.
module stack_ctrl32x8
    import stack_pkg::*;
#(
    parameter int WIDTH = stack_pkg::WIDTH,
    parameter int DEPTH = stack_pkg::DEPTH,
    parameter int AW    = stack_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             ready,
    output logic             err,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic [AW-1:0]    ram_adr,
    output logic [WIDTH-1:0] ram_in,
    output logic             ram_rws,
    output logic             ram_cs,
    input  logic [WIDTH-1:0] ram_out
);

    state_e           state_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             err_q;
    logic             ram_cs_q;
    logic             ram_rws_q;
    logic [AW-1:0]    ram_adr_q;

    logic [AW:0]      count_up_d;
    logic [AW:0]      count_dn_d;
    logic             full_d;
    logic             empty_d;

    assign count_up_d = count_q + (AW+1)'(1);
    assign count_dn_d = count_q - (AW+1)'(1);
    assign full_d     = (count_q == (AW+1)'(DEPTH));
    assign empty_d    = (count_q == '0);

    // RAM strobes are registered at request acceptance, so nothing reaches the RAM
    // combinationally from push, pop or din.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_data_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ram_cs_q  <= 1'b0;
            ram_rws_q <= 1'b0;
            ram_adr_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (push && pop) begin
                        err_q <= 1'b1;
                    end else if (push) begin
                        if (full_d) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= WRITE;
                            wr_data_q <= din;
                            ram_cs_q  <= 1'b1;
                            ram_rws_q <= 1'b1;
                            ram_adr_q <= count_q[AW-1:0];
                        end
                    end else if (pop) begin
                        if (empty_d) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= READ;
                            ram_cs_q  <= 1'b1;
                            ram_rws_q <= 1'b0;
                            ram_adr_q <= count_dn_d[AW-1:0];
                        end
                    end
                end
                WRITE: begin
                    state_q   <= IDLE;
                    count_q   <= count_up_d;
                    ram_cs_q  <= 1'b0;
                    ram_rws_q <= 1'b0;
                    ram_adr_q <= '0;
                end
                READ: begin
                    // ram_out is combinational from the RAM, valid during this cycle.
                    state_q   <= IDLE;
                    count_q   <= count_dn_d;
                    dout_q    <= ram_out;
                    valid_q   <= 1'b1;
                    ram_cs_q  <= 1'b0;
                    ram_rws_q <= 1'b0;
                    ram_adr_q <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    ram_cs_q  <= 1'b0;
                    ram_rws_q <= 1'b0;
                    ram_adr_q <= '0;
                end
            endcase
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign ready   = (state_q == IDLE);
    assign count   = count_q;
    assign full    = full_d;
    assign empty   = empty_d;
    assign ram_cs  = ram_cs_q;
    assign ram_rws = ram_rws_q;
    assign ram_adr = ram_adr_q;
    assign ram_in  = wr_data_q;

endmodule

// File: tb/tb_stack_ctrl32x8.sv
// Bench for stack_ctrl32x8: table vectors, corner sequences and random traffic
// against a queue-based stack model, with a behavioural 32x8 RAM attached.
module tb_stack_ctrl32x8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       valid, ready, err, full, empty;
    logic [5:0] count;
    logic [4:0] ram_adr;
    logic [7:0] ram_in;
    logic       ram_rws, ram_cs;
    logic [7:0] ram_out;

    logic [7:0] mem [32];

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    byte unsigned m_stk[$];
    int           m_pend;   // 0 none, 1 push in flight, 2 pop in flight
    logic [7:0]   m_pdata;
    logic [7:0]   m_dout;
    logic         m_valid;
    logic         m_err;
    int           m_adr;

    stack_ctrl32x8 dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .dout(dout), .valid(valid), .ready(ready), .err(err),
        .count(count), .full(full), .empty(empty),
        .ram_adr(ram_adr), .ram_in(ram_in), .ram_rws(ram_rws),
        .ram_cs(ram_cs), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && ram_rws) mem[ram_adr] <= ram_in;
    end
    assign ram_out = mem[ram_adr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update();
        if (!rst) begin
            m_stk.delete();
            m_pend = 0; m_valid = 1'b0; m_err = 1'b0; m_dout = 8'h00;
        end else begin
            m_valid = 1'b0;
            m_err = 1'b0;
            if (m_pend == 1) begin
                m_stk.push_back(m_pdata);
                m_pend = 0;
            end else if (m_pend == 2) begin
                m_dout = m_stk.pop_back();
                m_valid = 1'b1;
                m_pend = 0;
            end else if (push && pop) begin
                m_err = 1'b1;
            end else if (push) begin
                if (m_stk.size() == 32) m_err = 1'b1;
                else begin m_pend = 1; m_pdata = din; m_adr = m_stk.size(); end
            end else if (pop) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else begin m_pend = 2; m_adr = m_stk.size() - 1; end
            end
        end
    endtask

    task automatic model_check();
        chk("m_ready", 32'(ready), 32'(m_pend == 0));
        chk("m_count", 32'(count), 32'(m_stk.size()));
        chk("m_full",  32'(full),  32'(m_stk.size() == 32));
        chk("m_empty", 32'(empty), 32'(m_stk.size() == 0));
        chk("m_valid", 32'(valid), 32'(m_valid));
        chk("m_err",   32'(err),   32'(m_err));
        chk("m_dout",  32'(dout),  32'(m_dout));
        chk("m_cs",    32'(ram_cs), 32'(m_pend != 0));
        if (m_pend != 0) begin
            chk("m_rws", 32'(ram_rws), 32'(m_pend == 1));
            chk("m_adr", 32'(ram_adr), 32'(m_adr));
            if (m_pend == 1) chk("m_ram_in", 32'(ram_in), 32'(m_pdata));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    typedef struct {
        logic       push, pop;
        logic [7:0] din;
        logic       ready, cs, rws;
        logic [4:0] adr;
        logic [5:0] count;
        logic       valid, err;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [11];

    initial begin
        //           push pop din    rdy cs rws adr  cnt  vld err dout
        tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 5'd0, 6'd0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 5'd1, 6'd1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd2, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1, 6'd2, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd1, 1'b1, 1'b0, 8'h3C};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0, 8'h3C};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 8'hA5};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 8'hA5};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 8'hA5};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 8'hA5};

        m_pend = 0; m_pdata = 8'h00; m_dout = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_adr = 0;

        // Reset, then explicit reset values and three idle cycles
        rst = 1'b0;
        step(); step();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_ram_rws", 32'(ram_rws), 32'h0);
        chk("rst_ram_adr", 32'(ram_adr), 32'h0);
        chk("rst_ram_in", 32'(ram_in), 32'h0);
        rst = 1'b1;
        repeat (3) step();
        chk("idle_count", 32'(count), 32'h0);
        chk("idle_empty", 32'(empty), 32'h1);
        chk("idle_ready", 32'(ready), 32'h1);
        chk("idle_cs", 32'(ram_cs), 32'h0);

        // Table vectors: two pushes, two pops, ignored request, pop on empty
        for (int i = 0; i < 11; i++) begin
            push = tbl[i].push; pop = tbl[i].pop; din = tbl[i].din;
            step();
            chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_cs", i), 32'(ram_cs), 32'(tbl[i].cs));
            if (tbl[i].cs) begin
                chk($sformatf("tbl%0d_rws", i), 32'(ram_rws), 32'(tbl[i].rws));
                chk($sformatf("tbl%0d_adr", i), 32'(ram_adr), 32'(tbl[i].adr));
            end
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].count));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
        end
        push = 1'b0; pop = 1'b0;

        // Fill to 32, overflow push, drain in LIFO order
        for (int i = 0; i < 32; i++) begin
            push = 1'b1; din = 8'(i); step();
            push = 1'b0; step();
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'd32);
        push = 1'b1; din = 8'hEE; step();
        chk("ovf_err", 32'(err), 32'h1);
        chk("ovf_cs", 32'(ram_cs), 32'h0);
        push = 1'b0; step();
        chk("ovf_err_drop", 32'(err), 32'h0);
        chk("ovf_count", 32'(count), 32'd32);
        for (int i = 0; i < 32; i++) begin
            pop = 1'b1; step();
            pop = 1'b0; step();
            chk($sformatf("drain%0d_valid", i), 32'(valid), 32'h1);
            chk($sformatf("drain%0d_dout", i), 32'(dout), 32'(31 - i));
        end
        chk("drain_empty", 32'(empty), 32'h1);

        // Simultaneous push and pop at count=4
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; din = 8'(8'h40 + i); step();
            push = 1'b0; step();
        end
        push = 1'b1; pop = 1'b1; din = 8'h99; step();
        chk("both_err", 32'(err), 32'h1);
        chk("both_cs", 32'(ram_cs), 32'h0);
        chk("both_count", 32'(count), 32'd4);
        push = 1'b0; pop = 1'b0; step();
        chk("both_count2", 32'(count), 32'd4);

        // Reset during a WRITE at count=5
        push = 1'b1; din = 8'h44; step();
        push = 1'b0; step();
        push = 1'b1; din = 8'h55; step();
        chk("abort_pre_cs", 32'(ram_cs), 32'h1);
        chk("abort_pre_adr", 32'(ram_adr), 32'd5);
        push = 1'b0; rst = 1'b0; step();
        chk("abort_cs", 32'(ram_cs), 32'h0);
        chk("abort_count", 32'(count), 32'h0);
        chk("abort_ready", 32'(ready), 32'h1);
        rst = 1'b1; push = 1'b1; din = 8'h5A; step();
        chk("after_abort_cs", 32'(ram_cs), 32'h1);
        chk("after_abort_rws", 32'(ram_rws), 32'h1);
        chk("after_abort_adr", 32'(ram_adr), 32'h0);
        push = 1'b0; step();

        // Random traffic: push-heavy then pop-heavy, occasional reset
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst  = ($urandom_range(0, 299) != 0);
            push = (r < ((c % 1000) < 500 ? 60 : 25));
            pop  = ($urandom_range(0, 99) < ((c % 1000) < 500 ? 25 : 60));
            din  = 8'($urandom);
            step();
        end
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
